pc_gen_ras: RTL and testbench
=============================

Name: pc_gen_ras

Overview:
Parametrised program-counter generator for the CPU front end. It holds the fetch PC and computes the next PC from sequential, branch, jump, register-jump (return) and redirect sources. It supports stall, and it contains a return-address stack (RAS) of configurable depth for call/return. It sits between the control unit/ALU and instruction memory, and drives the word-aligned fetch address.

Parameters:
PC_W, 32, PC width in bits; legal range 8..64.
RESET_VEC, 0, PC value loaded on reset; must be a multiple of 4.
JIDX_W, 26, jump-index width; must be < PC_W-2.
RAS_DEPTH, 4, number of RAS entries; power of 2, at least 2.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous reset, active-low
stall_i  in  1  hold the PC; suppress RAS push/pop
redirect_i  in  1  exception/flush redirect; highest priority
redirect_pc_i  in  PC_W  redirect target
branch_i  in  1  conditional branch taken
branch_off_i  in  PC_W  sign-extended word offset
jump_i  in  1  absolute jump
jump_idx_i  in  JIDX_W  jump word index
call_i  in  1  qualifies jump_i as a call; push return address
ret_i  in  1  return / register jump
ret_reg_i  in  PC_W  register-file target for ret
pc_o  out  PC_W  current PC (registered)
pc_addr_o  out  PC_W-2  word address, pc_o[PC_W-1:2]
pc_plus4_o  out  PC_W  pc_o + 4 (combinational from pc_o)
ras_empty_o  out  1  RAS count == 0
ras_full_o  out  1  RAS count == RAS_DEPTH
misalign_o  out  1  registered one-cycle pulse: redirect target was not 4-aligned

Behaviour:
- Reset (async assert, sync release):
  - pc_o = RESET_VEC; misalign_o = 0.
  - RAS pointer = 0, count = 0, entries = 0; ras_empty_o = 1, ras_full_o = 0.
- All arithmetic is modulo 2^PC_W; wrap-around is silent.
  - p4 = pc_o + 4.
  - Branch target = p4 + (branch_off_i << 2).
  - Jump target = {p4[PC_W-1:JIDX_W+2], jump_idx_i, 2'b00}.
- Next-PC priority, one update per rising edge. Latency is one cycle: the PC selected from inputs at edge N is visible on pc_o after edge N.
  1. redirect_i: next = {redirect_pc_i[PC_W-1:2], 2'b00}. misalign_o = |redirect_pc_i[1:0] for one cycle. Applies even when stall_i = 1. No RAS change.
  2. stall_i: PC holds. No RAS change. All other requests are ignored.
  3. ret_i: next = RAS top if count > 0, else ret_reg_i with bits [1:0] forced to 0.
  4. jump_i: next = jump target.
  5. branch_i: next = branch target.
  6. Otherwise: next = p4.
- misalign_o is 0 on every cycle without a misaligned redirect.
- RAS is a circular buffer indexed by pointer tp, which points at the next free slot.
  - Push (call_i & jump_i, not stalled, not redirected): write p4 at tp; tp += 1 mod RAS_DEPTH; count = min(count+1, RAS_DEPTH).
  - Overflow: a push when full overwrites the oldest entry; count stays at RAS_DEPTH.
  - Pop (ret_i selected, count > 0): tp -= 1 mod RAS_DEPTH; count -= 1.
  - Pop when empty: no pointer/count change; ret_reg_i is used.
  - ret_i together with jump_i: ret wins, so no call push happens.
  - call_i without jump_i is ignored.
  - redirect_i does not flush the RAS.
- Reset mid-operation: all state returns to reset values immediately, independent of clk.

Decomposition:
- Shared package cpu_pkg holds:
  - RESET_VEC default and PC_W default.
  - next-PC source encoding enum: PCSRC_SEQ, PCSRC_BR, PCSRC_JMP, PCSRC_RET, PCSRC_RDR, used by debug/trace.
- One sub-module is natural: ras_stack.
  - Parametrised by WIDTH and DEPTH.
  - Ports: push, pop, push_data, top, empty, full.
  - Contains the circular storage plus pointer and count.
- pc_gen_ras keeps the priority mux and the PC register.

Test Plan:
- Reset with RESET_VEC=32'h0000_0100, no requests for 3 cycles -> pc_o = 0x100, 0x104, 0x108, 0x10C; pc_addr_o = 0x40, 0x41, 0x42, 0x43.
- At pc 0x200: branch_i=1, branch_off_i=-2 (0xFFFF_FFFE) -> next pc 0x1FC. Then stall_i=1 for 2 cycles with jump_i=1 -> pc holds at 0x1FC.
- At pc 0x1000_0010: jump_i=1, call_i=1, jump_idx_i=0x40 -> pc 0x1000_0100, RAS top 0x1000_0014. Later ret_i=1, ret_reg_i=0xDEAD_BEEC -> pc 0x1000_0014, ras_empty_o=1.
- RAS_DEPTH=4: 5 calls, return addresses A1..A5 -> ras_full_o=1. 4 rets return A5, A4, A3, A2. 5th ret uses ret_reg_i.
- Redirect while stall_i=1, redirect_pc_i=0x8000_0183 -> pc 0x8000_0180, misalign_o=1 for exactly one cycle, RAS count unchanged.
- At pc 0xFFFF_FFFC, no request -> pc wraps to 0x0000_0000. Assert rst_n=0 mid-cycle -> pc_o = RESET_VEC without waiting for a clock edge.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared front-end definitions: PC defaults and the next-PC source encoding
// exposed to debug/trace.
package cpu_pkg;

  localparam int unsigned PC_W_DEF      = 32;
  localparam logic [63:0] RESET_VEC_DEF = 64'h0;

  typedef enum logic [2:0] {
    PCSRC_SEQ,
    PCSRC_BR,
    PCSRC_JMP,
    PCSRC_RET,
    PCSRC_RDR
  } pc_src_e;

endpackage

// File: rtl/ras_stack.sv
// Return-address stack: circular buffer whose pointer names the next free slot.
// A push when full silently overwrites the oldest entry.
module ras_stack #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] top,
  output logic             empty,
  output logic             full
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  tp_q, tp_d;
  logic [CntW-1:0]  cnt_q, cnt_d;

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == CntW'(DEPTH));
  assign top   = mem_q[tp_q - PtrW'(1)];

  // Push takes precedence; the caller never raises both in one cycle.
  always_comb begin
    tp_d  = tp_q;
    cnt_d = cnt_q;
    if (push) begin
      tp_d = tp_q + PtrW'(1);
      if (!full) cnt_d = cnt_q + CntW'(1);
    end else if (pop && !empty) begin
      tp_d  = tp_q - PtrW'(1);
      cnt_d = cnt_q - CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tp_q  <= '0;
      cnt_q <= '0;
    end else begin
      tp_q  <= tp_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push) begin
      mem_q[tp_q] <= push_data;
    end
  end

endmodule

// File: rtl/pc_gen_ras.sv
// Fetch program-counter generator: priority next-PC mux, PC register and a
// return-address stack for call/return prediction.
module pc_gen_ras
  import cpu_pkg::*;
#(
  parameter int unsigned      PC_W      = PC_W_DEF,
  parameter logic [PC_W-1:0]  RESET_VEC = PC_W'(RESET_VEC_DEF),
  parameter int unsigned      JIDX_W    = 26,
  parameter int unsigned      RAS_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall_i,
  input  logic              redirect_i,
  input  logic [PC_W-1:0]   redirect_pc_i,
  input  logic              branch_i,
  input  logic [PC_W-1:0]   branch_off_i,
  input  logic              jump_i,
  input  logic [JIDX_W-1:0] jump_idx_i,
  input  logic              call_i,
  input  logic              ret_i,
  input  logic [PC_W-1:0]   ret_reg_i,
  output logic [PC_W-1:0]   pc_o,
  output logic [PC_W-3:0]   pc_addr_o,
  output logic [PC_W-1:0]   pc_plus4_o,
  output logic              ras_empty_o,
  output logic              ras_full_o,
  output logic              misalign_o
);

  localparam logic [PC_W-1:0] AlignMask = ~PC_W'(3);

  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] p4;
  logic [PC_W-1:0] br_tgt, jmp_tgt, ret_tgt, rdr_tgt;
  logic [PC_W-1:0] ras_top;
  logic            misalign_q, misalign_d;
  logic            advance;
  logic            ras_push, ras_pop;
  pc_src_e         pc_src;

  assign p4      = pc_q + PC_W'(4);
  assign br_tgt  = p4 + (branch_off_i << 2);
  assign jmp_tgt = {p4[PC_W-1:JIDX_W+2], jump_idx_i, 2'b00};
  assign rdr_tgt = redirect_pc_i & AlignMask;
  assign ret_tgt = ras_empty_o ? (ret_reg_i & AlignMask) : ras_top;

  // Redirect overrides stall; every other source is frozen while stalled.
  assign advance = !redirect_i && !stall_i;

  always_comb begin
    pc_src = PCSRC_SEQ;
    if (redirect_i)    pc_src = PCSRC_RDR;
    else if (ret_i)    pc_src = PCSRC_RET;
    else if (jump_i)   pc_src = PCSRC_JMP;
    else if (branch_i) pc_src = PCSRC_BR;
  end

  always_comb begin
    pc_d = p4;
    if (!redirect_i && stall_i) begin
      pc_d = pc_q;
    end else begin
      unique case (pc_src)
        PCSRC_RDR: pc_d = rdr_tgt;
        PCSRC_RET: pc_d = ret_tgt;
        PCSRC_JMP: pc_d = jmp_tgt;
        PCSRC_BR:  pc_d = br_tgt;
        PCSRC_SEQ: pc_d = p4;
        default:   pc_d = p4;
      endcase
    end
  end

  assign misalign_d = redirect_i && (|redirect_pc_i[1:0]);

  // Ret beats a simultaneous jump, so a call push never coincides with a pop.
  assign ras_pop  = advance && ret_i;
  assign ras_push = advance && !ret_i && jump_i && call_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= RESET_VEC;
      misalign_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      misalign_q <= misalign_d;
    end
  end

  ras_stack #(
    .WIDTH (PC_W),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (p4),
    .top       (ras_top),
    .empty     (ras_empty_o),
    .full      (ras_full_o)
  );

  assign pc_o       = pc_q;
  assign pc_addr_o  = pc_q[PC_W-1:2];
  assign pc_plus4_o = p4;
  assign misalign_o = misalign_q;

endmodule

// File: tb/tb_pc_gen_ras.sv
// Self-checking bench for pc_gen_ras: directed vector table, asynchronous
// reset corner, then randomized traffic against a queue-based reference model.
module tb_pc_gen_ras;

  localparam int unsigned PC_W   = 32;
  localparam int unsigned JIDX_W = 26;
  localparam int unsigned DEPTH  = 4;
  localparam logic [31:0] RV     = 32'h0000_0100;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              stall_i, redirect_i, branch_i, jump_i, call_i, ret_i;
  logic [PC_W-1:0]   redirect_pc_i, branch_off_i, ret_reg_i;
  logic [JIDX_W-1:0] jump_idx_i;
  logic [PC_W-1:0]   pc_o, pc_plus4_o;
  logic [PC_W-3:0]   pc_addr_o;
  logic              ras_empty_o, ras_full_o, misalign_o;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pc_gen_ras #(
    .PC_W      (PC_W),
    .RESET_VEC (RV),
    .JIDX_W    (JIDX_W),
    .RAS_DEPTH (DEPTH)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall_i       (stall_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .branch_i      (branch_i),
    .branch_off_i  (branch_off_i),
    .jump_i        (jump_i),
    .jump_idx_i    (jump_idx_i),
    .call_i        (call_i),
    .ret_i         (ret_i),
    .ret_reg_i     (ret_reg_i),
    .pc_o          (pc_o),
    .pc_addr_o     (pc_addr_o),
    .pc_plus4_o    (pc_plus4_o),
    .ras_empty_o   (ras_empty_o),
    .ras_full_o    (ras_full_o),
    .misalign_o    (misalign_o)
  );

  typedef struct {
    logic        rdr;
    logic [31:0] rdr_pc;
    logic        stall;
    logic        br;
    logic [31:0] off;
    logic        jmp;
    logic [25:0] idx;
    logic        call;
    logic        ret;
    logic [31:0] ret_reg;
    logic [31:0] exp_pc;
    logic        exp_empty;
    logic        exp_full;
    logic        exp_mis;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic rdr, logic [31:0] rdr_pc, logic stall, logic br,
                              logic [31:0] off, logic jmp, logic [25:0] idx, logic call,
                              logic ret, logic [31:0] ret_reg, logic [31:0] exp_pc,
                              logic exp_empty, logic exp_full, logic exp_mis);
    vec_t v;
    v.rdr = rdr; v.rdr_pc = rdr_pc; v.stall = stall; v.br = br; v.off = off;
    v.jmp = jmp; v.idx = idx; v.call = call; v.ret = ret; v.ret_reg = ret_reg;
    v.exp_pc = exp_pc; v.exp_empty = exp_empty; v.exp_full = exp_full; v.exp_mis = exp_mis;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    stall_i = 0; redirect_i = 0; branch_i = 0; jump_i = 0; call_i = 0; ret_i = 0;
    redirect_pc_i = '0; branch_off_i = '0; ret_reg_i = '0; jump_idx_i = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic [31:0] pc, input logic emp,
                           input logic ful, input logic mis);
    logic [31:0] p4;
    p4 = pc + 32'd4;
    check({tag, ".pc"}, pc_o, pc);
    check({tag, ".addr"}, pc_addr_o, pc[31:2]);
    check({tag, ".plus4"}, pc_plus4_o, p4);
    check({tag, ".empty"}, ras_empty_o, emp);
    check({tag, ".full"}, ras_full_o, ful);
    check({tag, ".mis"}, misalign_o, mis);
  endtask

  // Reference model state: the RAS as a bounded queue, newest at the back.
  logic [31:0] m_pc;
  logic        m_mis;
  logic [31:0] m_ras[$];

  task automatic model_step();
    logic [31:0] p4;
    p4    = m_pc + 32'd4;
    m_mis = 1'b0;
    if (redirect_i) begin
      m_pc  = redirect_pc_i & 32'hFFFF_FFFC;
      m_mis = (redirect_pc_i % 4) != 0;
    end else if (stall_i) begin
      m_pc = m_pc;
    end else if (ret_i) begin
      if (m_ras.size() > 0) m_pc = m_ras.pop_back();
      else                  m_pc = ret_reg_i & 32'hFFFF_FFFC;
    end else if (jump_i) begin
      if (call_i) begin
        m_ras.push_back(p4);
        if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
      end
      m_pc = (p4 & 32'hF000_0000) | (32'(jump_idx_i) * 4);
    end else if (branch_i) begin
      m_pc = p4 + branch_off_i * 4;
    end else begin
      m_pc = p4;
    end
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    #12;
    check_all("reset", RV, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 1; i <= 3; i++) begin
      tick();
      check_all($sformatf("seq%0d", i), RV + 32'(4 * i), 1'b1, 1'b0, 1'b0);
    end

    // rdr rdr_pc stall br off jmp idx call ret ret_reg | pc empty full mis
    vecs.push_back(mk(1, 32'h0000_0200, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0000_0200, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 32'hFFFF_FFFE, 0, 0, 0, 0, 0, 32'h0000_01FC, 1, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 1, 26'h5, 0, 0, 0, 32'h0000_01FC, 1, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 1, 26'h5, 0, 0, 0, 32'h0000_01FC, 1, 0, 0));
    vecs.push_back(mk(1, 32'h1000_0010, 0, 0, 0, 0, 0, 0, 0, 0, 32'h1000_0010, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 26'h40, 1, 0, 0, 32'h1000_0100, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hDEAD_BEEC, 32'h1000_0014, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hDEAD_BEEF, 32'hDEAD_BEEC, 1, 0, 0));
    vecs.push_back(mk(1, 32'h0000_1000, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0000_1000, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 26'h800, 1, 0, 0, 32'h0000_2000, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 26'hC00, 1, 0, 0, 32'h0000_3000, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 26'h1000, 1, 0, 0, 32'h0000_4000, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 26'h1400, 1, 0, 0, 32'h0000_5000, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 26'h1800, 1, 0, 0, 32'h0000_6000, 0, 1, 0));
    vecs.push_back(mk(1, 32'h8000_0183, 1, 0, 0, 0, 0, 0, 0, 0, 32'h8000_0180, 0, 1, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h8000_0184, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0BAD_0000, 32'h0000_5004, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0BAD_0000, 32'h0000_4004, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0BAD_0000, 32'h0000_3004, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0BAD_0000, 32'h0000_2004, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0BAD_0000, 32'h0BAD_0000, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 26'h99, 1, 1, 32'h0000_0700, 32'h0000_0700, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 32'h0000_0704, 1, 0, 0));
    vecs.push_back(mk(1, 32'hFFFF_FFFC, 0, 0, 0, 0, 0, 0, 0, 0, 32'hFFFF_FFFC, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0000_0000, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 32'h0000_0001, 0, 0, 0, 0, 0, 32'h0000_0008, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 26'h10, 1, 0, 0, 32'h0000_0040, 0, 0, 0));
    vecs.push_back(mk(1, 32'h0000_0300, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0000_0300, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 1, 32'h0000_0500, 32'h0000_0300, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0000_0500, 32'h0000_000C, 1, 0, 0));

    foreach (vecs[i]) begin
      redirect_i = vecs[i].rdr;  redirect_pc_i = vecs[i].rdr_pc;
      stall_i    = vecs[i].stall; branch_i = vecs[i].br; branch_off_i = vecs[i].off;
      jump_i     = vecs[i].jmp;  jump_idx_i = vecs[i].idx; call_i = vecs[i].call;
      ret_i      = vecs[i].ret;  ret_reg_i = vecs[i].ret_reg;
      tick();
      check_all($sformatf("vec%0d", i), vecs[i].exp_pc, vecs[i].exp_empty,
                vecs[i].exp_full, vecs[i].exp_mis);
    end

    // Asynchronous reset landing mid-cycle while RAS is loaded and misalign is high.
    idle_inputs();
    jump_i = 1; call_i = 1; jump_idx_i = 26'h20;
    tick();
    idle_inputs();
    redirect_i = 1; redirect_pc_i = 32'h0000_0402;
    tick();
    check_all("pre_rst", 32'h0000_0400, 1'b0, 1'b0, 1'b1);
    idle_inputs();
    #2 rst_n = 1'b0;
    #1;
    check_all("async_rst", RV, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    m_pc  = RV;
    m_mis = 1'b0;
    m_ras.delete();
    for (int i = 0; i < 600; i++) begin
      redirect_i    = ($urandom_range(15) == 0);
      redirect_pc_i = $urandom;
      stall_i       = ($urandom_range(7) == 0);
      ret_i         = ($urandom_range(4) == 0);
      jump_i        = ($urandom_range(3) == 0);
      call_i        = ($urandom_range(1) == 0);
      branch_i      = ($urandom_range(2) == 0);
      branch_off_i  = $urandom;
      jump_idx_i    = JIDX_W'($urandom);
      ret_reg_i     = $urandom;
      model_step();
      tick();
      check("rnd.pc", pc_o, m_pc);
      check("rnd.plus4", pc_plus4_o, m_pc + 32'd4);
      check("rnd.empty", ras_empty_o, m_ras.size() == 0);
      check("rnd.full", ras_full_o, m_ras.size() == DEPTH);
      check("rnd.mis", misalign_o, m_mis);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
